// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant at a time, rotating priority
// pointer, optional hold limit with a revoke pulse when a grant times out.
module rr_arbiter #(
  parameter int number_ports = 2,
  parameter int max_hold = 0,
  localparam int W = $clog2(number_ports)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [number_ports-1:0] request,
  output logic [number_ports-1:0] grant,
  output logic                    grant_valid,
  output logic [W-1:0]            chosen,
  output logic                    revoked
);

  localparam int HW = (max_hold > 1) ? $clog2(max_hold) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((max_hold > 0) ? max_hold - 1 : 0);
  localparam logic [HW-1:0] HOLD_SAT = '1;
  localparam logic [W-1:0] PORT_LAST = W'(number_ports - 1);
  localparam logic [number_ports-1:0] ONE_HOT0 = number_ports'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  ptr;
  logic [HW-1:0] hold_cnt;
  logic [W-1:0]  winner;
  logic [W:0]    slot;
  logic [W-1:0]  next_ptr;
  logic          timeout;

  // Scan from the highest rotated offset down so the lowest requesting offset wins;
  // the slot is folded back below number_ports so non-power-of-two sizes never overrun.
  always_comb begin
    winner = '0;
    slot   = '0;
    for (int i = number_ports - 1; i >= 0; i--) begin
      slot = {1'b0, ptr} + (W+1)'(i);
      if (slot >= (W+1)'(number_ports)) slot = slot - (W+1)'(number_ports);
      if (request[slot[W-1:0]]) winner = slot[W-1:0];
    end
  end

  assign next_ptr    = (chosen == PORT_LAST) ? '0 : chosen + 1'b1;
  assign timeout     = (max_hold != 0) && (hold_cnt == HOLD_LAST);
  assign grant_valid = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      chosen   <= '0;
      revoked  <= 1'b0;
    end else begin
      revoked <= 1'b0;
      case (state)
        IDLE: begin
          if (|request) begin
            grant    <= ONE_HOT0 << winner;
            chosen   <= winner;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A drop coinciding with the timeout is an ordinary release, not a revoke.
          if (!request[chosen]) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else if (timeout) begin
            grant   <= '0;
            ptr     <= next_ptr;
            revoked <= 1'b1;
            state   <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (4 ports, 4 ports with max_hold=3, 3 ports)
// checked by directed scenarios and random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req4 = '0, req4h = '0;
  logic [2:0] req3 = '0;
  logic [3:0] g4, g4h;
  logic [2:0] g3;
  logic [1:0] ch4, ch4h, ch3;
  logic gv4, gv4h, gv3, rv4, rv4h, rv3;

  int checks = 0;
  int failures = 0;

  rr_arbiter #(.number_ports(4), .max_hold(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .request(req4), .grant(g4),
    .grant_valid(gv4), .chosen(ch4), .revoked(rv4));
  rr_arbiter #(.number_ports(4), .max_hold(3)) dut4h (
    .clk(clk), .rst_n(rst_n), .request(req4h), .grant(g4h),
    .grant_valid(gv4h), .chosen(ch4h), .revoked(rv4h));
  rr_arbiter #(.number_ports(3), .max_hold(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .request(req3), .grant(g3),
    .grant_valid(gv3), .chosen(ch3), .revoked(rv3));

  always #5 clk = ~clk;

  // Reference model: owner = granted port or -1, held = cycles the grant has been visible.
  int m_owner[3] = '{-1, -1, -1};
  int m_ptr[3]   = '{0, 0, 0};
  int m_held[3]  = '{0, 0, 0};
  bit m_rev[3]   = '{0, 0, 0};
  int np[3]      = '{4, 4, 3};
  int mh[3]      = '{0, 3, 0};
  int mp;

  function automatic bit req_bit(int k, int p);
    case (k)
      0: return req4[p];
      1: return req4h[p];
      default: return req3[p];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_owner[k] = -1; m_ptr[k] = 0; m_held[k] = 0; m_rev[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_rev[k] = 0;
        if (m_owner[k] < 0) begin
          for (int i = 0; i < np[k]; i++) begin
            mp = (m_ptr[k] + i) % np[k];
            if (m_owner[k] < 0 && req_bit(k, mp)) begin
              m_owner[k] = mp;
              m_held[k] = 1;
            end
          end
        end else if (!req_bit(k, m_owner[k])) begin
          m_ptr[k] = (m_owner[k] + 1) % np[k];
          m_owner[k] = -1;
        end else if (mh[k] != 0 && m_held[k] == mh[k]) begin
          m_ptr[k] = (m_owner[k] + 1) % np[k];
          m_owner[k] = -1;
          m_rev[k] = 1;
        end else begin
          m_held[k] = m_held[k] + 1;
        end
      end
    end
  end

  function automatic int exp_grant(int k);
    return (m_owner[k] < 0) ? 0 : (1 << m_owner[k]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req4 = '0; req4h = '0; req3 = '0;
    #12;
    checks++;
    if ({g4, g4h, g3} !== 11'd0) begin
      $display("FAIL reset_grant: got %b %b %b expected all zero", g4, g4h, g3); failures++;
    end
    checks++;
    if ({gv4, gv4h, gv3, rv4, rv4h, rv3} !== 6'd0) begin
      $display("FAIL reset_valid_revoked: got %b expected 0", {gv4, gv4h, gv3, rv4, rv4h, rv3}); failures++;
    end
    checks++;
    if ({ch4, ch4h, ch3} !== 6'd0) begin
      $display("FAIL reset_chosen: got %b expected 0", {ch4, ch4h, ch3}); failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (g4 !== 4'd0) begin
      $display("FAIL post_reset_idle: got %b expected 0000", g4); failures++;
    end
  endtask

  task automatic test_basic_and_handoff();
    req4 = 4'b1010;
    @(negedge clk);
    checks++;
    if (g4 !== 4'b0010 || ch4 !== 2'd1 || gv4 !== 1'b1) begin
      $display("FAIL first_grant: got grant=%b chosen=%0d valid=%b expected 0010 1 1", g4, ch4, gv4); failures++;
    end
    req4 = 4'b1000;
    @(negedge clk);
    checks++;
    if (g4 !== 4'b0000 || gv4 !== 1'b0) begin
      $display("FAIL release_idle: got grant=%b valid=%b expected 0000 0", g4, gv4); failures++;
    end
    checks++;
    if (dut4.ptr !== 2'd2) begin
      $display("FAIL ptr_after_release: got %0d expected 2", dut4.ptr); failures++;
    end
    @(negedge clk);
    checks++;
    if (g4 !== 4'b1000 || ch4 !== 2'd3) begin
      $display("FAIL handoff_grant: got grant=%b chosen=%0d expected 1000 3", g4, ch4); failures++;
    end
    req4 = 4'b0000;
    @(negedge clk);
    checks++;
    if (g4 !== 4'b0000) begin
      $display("FAIL handoff_release: got %b expected 0000", g4); failures++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expv;
    req4 = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      expv = 4'(1 << (e % 4));
      @(negedge clk);
      checks++;
      if (g4 !== expv || ch4 !== 2'(e % 4)) begin
        $display("FAIL rr_grant_%0d: got grant=%b chosen=%0d expected %b %0d", e, g4, ch4, expv, e % 4); failures++;
      end
      @(negedge clk);
      checks++;
      if (g4 !== expv) begin
        $display("FAIL rr_hold_%0d: got %b expected %b", e, g4, expv); failures++;
      end
      req4[e % 4] = 1'b0;
      @(negedge clk);
      checks++;
      if (g4 !== 4'b0000) begin
        $display("FAIL rr_gap_%0d: got %b expected 0000", e, g4); failures++;
      end
      req4[e % 4] = 1'b1;
    end
    req4 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0] eg[13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100,
                           4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100};
    logic       er[13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    req4h = 4'b0101;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      checks++;
      if (g4h !== eg[c] || rv4h !== er[c]) begin
        $display("FAIL timeout_cycle_%0d: got grant=%b revoked=%b expected %b %b", c, g4h, rv4h, eg[c], er[c]);
        failures++;
      end
      // Owner drops exactly on its last allowed cycle: must be a plain release.
      if (c == 10) req4h = 4'b0100;
    end
    req4h = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wrap3();
    req3 = 3'b010;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b010 || ch3 !== 2'd1) begin
      $display("FAIL wrap_first: got grant=%b chosen=%0d expected 010 1", g3, ch3); failures++;
    end
    req3 = 3'b000;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b000 || dut3.ptr !== 2'd2) begin
      $display("FAIL wrap_release: got grant=%b ptr=%0d expected 000 2", g3, dut3.ptr); failures++;
    end
    req3 = 3'b011;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b001 || ch3 !== 2'd0) begin
      $display("FAIL wrap_winner: got grant=%b chosen=%0d expected 001 0", g3, ch3); failures++;
    end
    req3 = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req4 = 4'b0100;
    @(negedge clk);
    checks++;
    if (g4 !== 4'b0100) begin
      $display("FAIL areset_setup: got %b expected 0100", g4); failures++;
    end
    #2;
    rst_n = 1'b0;
    #0.5;
    checks++;
    if (g4 !== 4'b0000 || gv4 !== 1'b0 || dut4.ptr !== 2'd0) begin
      $display("FAIL areset_immediate: got grant=%b valid=%b ptr=%0d expected 0000 0 0", g4, gv4, dut4.ptr);
      failures++;
    end
    #0.5;
    rst_n = 1'b1;
    req4 = 4'b1001;
    @(negedge clk);
    checks++;
    if (g4 !== 4'b0001 || ch4 !== 2'd0) begin
      $display("FAIL areset_port0_first: got grant=%b chosen=%0d expected 0001 0", g4, ch4); failures++;
    end
    req4 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (g4 !== 4'(exp_grant(0)) || gv4 !== (m_owner[0] >= 0) || rv4 !== m_rev[0] ||
          (m_owner[0] >= 0 && ch4 !== 2'(m_owner[0]))) begin
        $display("FAIL rand4_%0d: got grant=%b chosen=%0d revoked=%b expected grant=%b revoked=%b",
                 c, g4, ch4, rv4, 4'(exp_grant(0)), m_rev[0]); failures++;
      end
      checks++;
      if (g4h !== 4'(exp_grant(1)) || gv4h !== (m_owner[1] >= 0) || rv4h !== m_rev[1] ||
          (m_owner[1] >= 0 && ch4h !== 2'(m_owner[1]))) begin
        $display("FAIL rand4h_%0d: got grant=%b chosen=%0d revoked=%b expected grant=%b revoked=%b",
                 c, g4h, ch4h, rv4h, 4'(exp_grant(1)), m_rev[1]); failures++;
      end
      checks++;
      if (g3 !== 3'(exp_grant(2)) || gv3 !== (m_owner[2] >= 0) || rv3 !== m_rev[2] ||
          (m_owner[2] >= 0 && ch3 !== 2'(m_owner[2]))) begin
        $display("FAIL rand3_%0d: got grant=%b chosen=%0d revoked=%b expected grant=%b revoked=%b",
                 c, g3, ch3, rv3, 3'(exp_grant(2)), m_rev[2]); failures++;
      end
      checks++;
      if ($countones(g4) > 1 || $countones(g4h) > 1 || $countones(g3) > 1) begin
        $display("FAIL rand_onehot_%0d: got %b %b %b expected at most one bit each", c, g4, g4h, g3);
        failures++;
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) req4[b] = ~req4[b];
        if ($urandom_range(5) == 0) req4h[b] = ~req4h[b];
        if (b < 3 && $urandom_range(3) == 0) req3[b] = ~req3[b];
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_handoff();
    test_round_robin();
    test_timeout();
    test_wrap3();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter number_ports, default 2, giving the number of requesting ports; legal range is 2 to 32, and values need not be powers of two.
REQ-002 The block SHALL have parameter max_hold, default 0, giving the maximum number of cycles a grant is held; 0 means no limit.
REQ-003 Width W SHALL be $clog2(number_ports).
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 request  input  number_ports  per-port request; held high by a port for the whole of its transaction.
REQ-007 grant  output  number_ports  one-hot grant, registered.
REQ-008 grant_valid  output  1  high while any grant is held; equals the OR of grant.
REQ-009 chosen  output  W  index of the granted port, registered; meaningful only while grant_valid is high.
REQ-010 revoked  output  1  one-cycle pulse when a grant ends by timeout instead of by request drop.

Function
REQ-011 The block SHALL keep a priority pointer ptr of width W, holding values 0 to number_ports-1.
REQ-012 Rotation SHALL be rot[i] = request[(ptr+i) mod number_ports] for i in 0 to number_ports-1.
REQ-013 The modulo in REQ-012 SHALL wrap correctly for non-power-of-two number_ports and SHALL never index past number_ports-1.
REQ-014 Selection SHALL take idx = the lowest i with rot[i]==1 (priority encode), and winner = (ptr+idx) mod number_ports.
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE with request==0: stay in IDLE; grant=0, grant_valid=0.
REQ-017 In IDLE with request!=0: at the next edge, grant=1<<winner, chosen=winner, hold_cnt=0, and the state goes to GRANT.
REQ-018 Grant latency SHALL be exactly one cycle from a sampled request in IDLE.
REQ-019 In GRANT, grant and chosen SHALL stay stable; requests from other ports are ignored, with no preemption.
REQ-020 In GRANT with request[chosen]==0 sampled: the next edge clears grant, sets ptr=(chosen+1) mod number_ports, and returns to IDLE.
REQ-021 In GRANT with max_hold!=0, request[chosen] still high and hold_cnt==max_hold-1: the next edge clears grant, sets ptr=(chosen+1) mod number_ports, pulses revoked for exactly 1 cycle, and returns to IDLE.
REQ-022 Otherwise in GRANT, hold_cnt SHALL increment by 1; it saturates and never wraps.
REQ-023 The hold_cnt width SHALL be enough to hold max_hold-1, with a minimum of 1 bit.
REQ-024 Every grant SHALL be followed by at least one IDLE cycle before the next grant, even with back-to-back requests.
REQ-025 ptr SHALL change only on grant release or revoke.
REQ-026 If the owner drops its request in the same cycle the timeout is reached, it SHALL be treated as a normal release: revoked stays 0.
REQ-027 A revoked port that keeps its request high SHALL compete again in IDLE at lowest priority, because ptr has moved past it.
REQ-028 A request that rises and falls entirely inside another port's GRANT SHALL be lost; no request latching is done.
REQ-029 grant SHALL always have 0 or 1 bits set.

Reset
REQ-030 While rst_n==0, immediately and independent of clk: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_valid=0, chosen=0, revoked=0.
REQ-031 Reset asserted mid-grant SHALL drop grant at once, and ptr SHALL return to 0.
REQ-032 After rst_n rises, the first arbitration SHALL favour port 0.

Verification (number_ports=4 unless stated)
REQ-033 Reset, then request=4'b1010 -> one cycle later grant=4'b0010, chosen=1.
REQ-034 Port 1 drops its request while port 3 holds -> grant=0 for 1 cycle, then grant=4'b1000, chosen=3, ptr=2 during the arbitration.
REQ-035 request=4'b1111 held, each owner dropping after 2 cycles -> grant order 0,1,2,3,0, with one idle cycle between each.
REQ-036 max_hold=3, request=4'b0101 held constant -> port 0 granted 3 cycles, revoked pulses, then port 2 granted, then port 0 again.
REQ-037 number_ports=3, ptr=2 after a port-1 release, request=3'b011 -> winner 0, showing the wrap with no out-of-range index.
REQ-038 rst_n pulsed low for 1 ns mid-grant, off a clock edge -> grant=0 at once; next request=4'b1001 -> port 0 granted.
